// File: rtl/vpe_relu_rf_writeback_pkg.sv
// Shared VPE writeback types and sizes.
// Lane geometry, RF merge-mode encodings and FSM state.
package vpe_pkg;

  localparam int VPE_LANES    = 8;
  localparam int VPE_DW       = 8;
  localparam int VPE_RF_DEPTH = 32;
  localparam int VPE_IDX_W    = $clog2(VPE_RF_DEPTH);
  localparam int VPE_W        = VPE_LANES * VPE_DW;

  typedef enum logic [1:0] {
    RF_MUX_FULL = 2'b00,
    RF_MUX_LO   = 2'b01,
    RF_MUX_HI   = 2'b10,
    RF_MUX_ACC  = 2'b11
  } rf_mux_t;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_CLEAR = 1'b1
  } wb_state_t;

endpackage

// File: rtl/vpe_relu_rf_writeback_if.sv
// Writeback-stage bus: vector input, clear, read port, status.
// master drives requests, slave is the writeback stage.
interface vpe_relu_rf_writeback_if;
  import vpe_pkg::*;

  logic [VPE_W-1:0]     i_data;
  logic                 i_data_v;
  logic                 i_en_relu;
  logic [VPE_IDX_W-1:0] i_rf_idx;
  logic [1:0]           i_rf_mux;
  logic                 i_clr;
  logic                 i_rd_en;
  logic [VPE_IDX_W-1:0] i_rd_idx;
  logic [VPE_W-1:0]     o_rd_data;
  logic                 o_rd_v;
  logic                 o_wr_v;
  logic [VPE_IDX_W-1:0] o_wr_idx;
  logic                 o_clr_busy;
  logic                 o_drop_err;

  modport master (
    output i_data, i_data_v, i_en_relu,
    output i_rf_idx, i_rf_mux, i_clr,
    output i_rd_en, i_rd_idx,
    input  o_rd_data, o_rd_v, o_wr_v,
    input  o_wr_idx, o_clr_busy, o_drop_err
  );

  modport slave (
    input  i_data, i_data_v, i_en_relu,
    input  i_rf_idx, i_rf_mux, i_clr,
    input  i_rd_en, i_rd_idx,
    output o_rd_data, o_rd_v, o_wr_v,
    output o_wr_idx, o_clr_busy, o_drop_err
  );

endinterface

// File: rtl/vpe_relu_rf_writeback_sat_add8.sv
// Lane-local signed int8 add, saturated to [-128,127].
// Overflow is read from the top two bits of a 9-bit sum.
module vpe_lane_sat_add8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] sum_o
);

  logic [8:0] sum;

  // sign-extended add, then clamp on overflow
  always_comb begin
    sum   = {a_i[7], a_i} + {b_i[7], b_i};
    sum_o = sum[7:0];
    if (sum[8:7] == 2'b01) begin
      sum_o = 8'h7f;
    end else if (sum[8:7] == 2'b10) begin
      sum_o = 8'h80;
    end
  end

endmodule

// File: rtl/vpe_relu_rf_writeback.sv
// ReLU + merge writeback into a 32x64 flop register file.
// Bypassed read port and a zero-sweep clear FSM.
module vpe_relu_rf_writeback
  import vpe_pkg::*;
#(
  parameter int LANES    = VPE_LANES,
  parameter int DW       = VPE_DW,
  parameter int RF_DEPTH = VPE_RF_DEPTH,
  parameter int IDX_W    = $clog2(RF_DEPTH)
) (
  input logic clk,
  input logic rst_n,
  vpe_relu_rf_writeback_if.slave bus
);

  localparam int W = LANES * DW;

  logic [W-1:0]     rf_q [RF_DEPTH];
  logic             s1_v_q;
  logic [W-1:0]     s1_data_q;
  logic [IDX_W-1:0] s1_idx_q;
  rf_mux_t          s1_mux_q;
  wb_state_t        state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             drop_err_q, drop_err_d;
  logic             clr_we;
  logic             wr_en;
  logic [W-1:0]     relu_d;
  logic [W-1:0]     old_word;
  logic [W-1:0]     acc_word;
  logic [W-1:0]     merged;
  logic [W-1:0]     rd_word;
  logic [W-1:0]     rd_data_q;
  logic             rd_v_q;
  logic             wr_v_q;
  logic [IDX_W-1:0] wr_idx_q;

  // ReLU zeroes negative lanes before capture
  always_comb begin
    relu_d = bus.i_data;
    for (int k = 0; k < LANES; k++) begin
      if (bus.i_en_relu && bus.i_data[k*DW+DW-1]) begin
        relu_d[k*DW +: DW] = '0;
      end
    end
  end

  // S1 input register; only valid clears on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_idx_q  <= '0;
      s1_mux_q  <= RF_MUX_FULL;
    end else begin
      s1_v_q <= bus.i_data_v;
      if (bus.i_data_v) begin
        s1_data_q <= relu_d;
        s1_idx_q  <= bus.i_rf_idx;
        s1_mux_q  <= rf_mux_t'(bus.i_rf_mux);
      end
    end
  end

  assign old_word = rf_q[s1_idx_q];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    vpe_lane_sat_add8 u_sat (
      .a_i   (old_word[k*DW +: DW]),
      .b_i   (s1_data_q[k*DW +: DW]),
      .sum_o (acc_word[k*DW +: DW])
    );
  end

  // S2 merge of the captured vector into the old entry
  always_comb begin
    merged = s1_data_q;
    unique case (s1_mux_q)
      RF_MUX_FULL: merged = s1_data_q;
      RF_MUX_LO:   merged = {old_word[W-1:W/2],
                             s1_data_q[W/2-1:0]};
      RF_MUX_HI:   merged = {s1_data_q[W-1:W/2],
                             old_word[W/2-1:0]};
      RF_MUX_ACC:  merged = acc_word;
      default:     merged = s1_data_q;
    endcase
  end

  assign wr_en = s1_v_q && (state_q == WB_IDLE);

  // clear FSM: sweep, ignore re-clear, flag dropped writes
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    drop_err_d = drop_err_q;
    clr_we     = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (bus.i_clr) begin
          state_d    = WB_CLEAR;
          clr_cnt_d  = '0;
          drop_err_d = 1'b0;
        end
      end
      WB_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (s1_v_q) begin
          drop_err_d = 1'b1;
        end
        if (clr_cnt_q == IDX_W'(RF_DEPTH - 1)) begin
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // FSM state, sweep counter and sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WB_IDLE;
      clr_cnt_q  <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      drop_err_q <= drop_err_d;
    end
  end

  // register file: sweep has priority, writes only in idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else if (clr_we) begin
      rf_q[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      rf_q[s1_idx_q] <= merged;
    end
  end

  // read word with write-through of this cycle's update
  always_comb begin
    rd_word = rf_q[bus.i_rd_idx];
    if (wr_en && (s1_idx_q == bus.i_rd_idx)) begin
      rd_word = merged;
    end
    if (clr_we && (clr_cnt_q == bus.i_rd_idx)) begin
      rd_word = '0;
    end
  end

  // registered read data and write strobe outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_v_q    <= 1'b0;
      wr_v_q    <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      rd_v_q <= bus.i_rd_en;
      wr_v_q <= wr_en;
      if (bus.i_rd_en) begin
        rd_data_q <= rd_word;
      end
      if (wr_en) begin
        wr_idx_q <= s1_idx_q;
      end
    end
  end

  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_rd_v     = rd_v_q;
  assign bus.o_wr_v     = wr_v_q;
  assign bus.o_wr_idx   = wr_idx_q;
  assign bus.o_clr_busy = (state_q == WB_CLEAR);
  assign bus.o_drop_err = drop_err_q;

endmodule

// File: tb/tb_vpe_relu_rf_writeback.sv
// Scoreboard bench for vpe_relu_rf_writeback.
// Reference model tracks RF contents and clear sweep by cycle.
module tb_vpe_relu_rf_writeback;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vpe_relu_rf_writeback_if bus ();

  vpe_relu_rf_writeback dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] m_rf [32];
  bit          m_s1_v;
  logic [63:0] m_s1_d;
  int          m_s1_idx;
  int          m_s1_mux;
  bit          m_clear;
  int          m_cnt;
  bit          m_drop;

  logic [63:0] rd_q [$];
  int          wr_q [$];

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  function automatic logic [63:0] relu(logic [63:0] d,
                                       bit en);
    logic [63:0] r;
    byte v;
    r = d;
    for (int k = 0; k < 8; k++) begin
      v = d[k*8 +: 8];
      if (en && v < 0) r[k*8 +: 8] = 8'h00;
    end
    return r;
  endfunction

  function automatic logic [63:0] merge(logic [63:0] o,
                                        logic [63:0] n,
                                        int mux);
    logic [63:0] r;
    byte a, b;
    int s;
    case (mux)
      0: r = n;
      1: r = {o[63:32], n[31:0]};
      2: r = {n[63:32], o[31:0]};
      default: begin
        for (int k = 0; k < 8; k++) begin
          a = o[k*8 +: 8];
          b = n[k*8 +: 8];
          s = int'(a) + int'(b);
          if (s > 127) s = 127;
          if (s < -128) s = -128;
          r[k*8 +: 8] = 8'(s);
        end
      end
    endcase
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_s1_v = 0;
    m_s1_d = '0;
    m_s1_idx = 0;
    m_s1_mux = 0;
    m_clear = 0;
    m_cnt = 0;
    m_drop = 0;
  endfunction

  // what the upcoming clock edge does, given current inputs
  function automatic void model_edge();
    if (m_clear) begin
      if (m_s1_v) m_drop = 1;
      m_rf[m_cnt] = '0;
    end else if (m_s1_v) begin
      m_rf[m_s1_idx] = merge(m_rf[m_s1_idx], m_s1_d,
                             m_s1_mux);
      wr_q.push_back(m_s1_idx);
    end
    if (bus.i_rd_en) rd_q.push_back(m_rf[int'(bus.i_rd_idx)]);
    if (m_clear) begin
      if (m_cnt == 31) m_clear = 0;
      m_cnt = (m_cnt + 1) % 32;
    end else if (bus.i_clr) begin
      m_clear = 1;
      m_cnt = 0;
      m_drop = 0;
    end
    m_s1_v = bus.i_data_v;
    if (bus.i_data_v) begin
      m_s1_d = relu(bus.i_data, bus.i_en_relu);
      m_s1_idx = int'(bus.i_rf_idx);
      m_s1_mux = int'(bus.i_rf_mux);
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #3;
    bus.i_data_v = 1'b0;
    bus.i_clr = 1'b0;
    bus.i_rd_en = 1'b0;
  endtask

  task automatic set_wr(int idx, int mux, bit rl,
                        logic [63:0] d);
    bus.i_data_v = 1'b1;
    bus.i_rf_idx = 5'(idx);
    bus.i_rf_mux = 2'(mux);
    bus.i_en_relu = rl;
    bus.i_data = d;
  endtask

  task automatic set_rd(int idx);
    bus.i_rd_en = 1'b1;
    bus.i_rd_idx = 5'(idx);
  endtask

  task automatic chk_outs_zero(string tag);
    chk({tag, "_rd_data"}, bus.o_rd_data, 64'h0);
    chk({tag, "_rd_v"}, 64'(bus.o_rd_v), 64'h0);
    chk({tag, "_wr_v"}, 64'(bus.o_wr_v), 64'h0);
    chk({tag, "_wr_idx"}, 64'(bus.o_wr_idx), 64'h0);
    chk({tag, "_clr_busy"}, 64'(bus.o_clr_busy), 64'h0);
    chk({tag, "_drop_err"}, 64'(bus.o_drop_err), 64'h0);
  endtask

  // monitor: pop expectations whenever the DUT presents output
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bus.o_rd_v) begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", 64'(bus.o_rd_v), 64'h0);
        end else begin
          chk("rd_data", bus.o_rd_data, rd_q.pop_front());
        end
      end else if (rd_q.size() != 0) begin
        chk("rd_missing", 64'(bus.o_rd_v), 64'h1);
        void'(rd_q.pop_front());
      end
      if (bus.o_wr_v) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 64'(bus.o_wr_v), 64'h0);
        end else begin
          chk("wr_idx", 64'(bus.o_wr_idx),
              64'(wr_q.pop_front()));
        end
      end else if (wr_q.size() != 0) begin
        chk("wr_missing", 64'(bus.o_wr_v), 64'h1);
        void'(wr_q.pop_front());
      end
      chk("clr_busy", 64'(bus.o_clr_busy), 64'(m_clear));
      chk("drop_err", 64'(bus.o_drop_err), 64'(m_drop));
    end
  end

  initial begin
    bus.i_data = '0;
    bus.i_data_v = 1'b0;
    bus.i_en_relu = 1'b0;
    bus.i_rf_idx = '0;
    bus.i_rf_mux = '0;
    bus.i_clr = 1'b0;
    bus.i_rd_en = 1'b0;
    bus.i_rd_idx = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk_outs_zero("reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // full write with ReLU, then read back
    set_wr(3, 0, 1, 64'h807FFF01_008110F0);
    tick();
    tick();
    set_rd(3);
    tick();
    tick();

    // half writes to idx 7
    set_wr(7, 1, 0, 64'h12345678_AAAAAAAA);
    tick();
    set_wr(7, 2, 0, 64'hBBBBBBBB_87654321);
    tick();
    tick();
    set_rd(7);
    tick();
    tick();

    // saturating accumulate, then back-to-back chain
    set_wr(5, 0, 0, 64'h00000000_00059070);
    tick();
    set_wr(5, 3, 0, 64'h00000000_00FEF020);
    tick();
    set_wr(5, 3, 0, 64'h01010101_01010101);
    tick();
    set_wr(5, 3, 0, 64'h7F7F7F7F_80808080);
    tick();
    set_wr(5, 3, 1, 64'hC0407F81_10F02030);
    tick();
    tick();
    set_rd(5);
    tick();
    tick();

    // bypass: read in the S2 cycle of the write
    set_wr(9, 0, 0, 64'h11223344_55667788);
    tick();
    set_rd(9);
    tick();
    tick();

    // clear sweep with a write injected 5 cycles in
    bus.i_clr = 1'b1;
    tick();
    repeat (4) tick();
    set_wr(2, 0, 0, 64'hDEADBEEF_CAFEF00D);
    tick();
    bus.i_clr = 1'b1;
    tick();
    repeat (28) tick();
    for (int i = 0; i < 32; i++) begin
      set_rd(i);
      tick();
    end
    bus.i_clr = 1'b1;
    tick();
    repeat (33) tick();

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        set_wr(($urandom_range(0, 2) == 0)
                 ? $urandom_range(0, 31)
                 : $urandom_range(0, 3),
               $urandom_range(0, 3),
               1'($urandom_range(0, 1)),
               {$urandom, $urandom});
      end
      if ($urandom_range(0, 1) == 1) begin
        set_rd($urandom_range(0, 31));
      end
      if ($urandom_range(0, 59) == 0) bus.i_clr = 1'b1;
      tick();
    end
    repeat (40) tick();
    for (int i = 0; i < 32; i++) begin
      set_wr(i, 0, 0, {$urandom, $urandom});
      tick();
    end
    tick();

    // asynchronous reset at sweep cycle 10
    bus.i_clr = 1'b1;
    tick();
    repeat (9) tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk_outs_zero("midsweep");
    model_reset();
    rd_q.delete();
    wr_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_rd(i);
      tick();
    end
    repeat (3) tick();

    chk("rd_q_drained", 64'(rd_q.size()), 64'h0);
    chk("wr_q_drained", 64'(wr_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/vpe_relu_rf_writeback.md
# vpe_relu_rf_writeback

Writeback stage directly downstream of the VPE bias adder. It takes the biased 8×int8 activation vector with its `en_relu` / `rf_idx` / `rf_mux` side-band, applies optional ReLU, and merges the result into a 32-entry × 64-bit activation register file. Merge modes are full, low-half, high-half, or saturating accumulate. The block also provides a bypassed read port for the next layer's operand fetch and a sweep-clear FSM.

## Interface
Parameters:
- `LANES`, 8, int8 lanes per vector
- `DW`, 8, lane width (signed two's complement)
- `RF_DEPTH`, 32, register-file entries
- `IDX_W`, 5, index width (`log2(RF_DEPTH)`)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `i_data`  in  64  biased activation vector; lane k = `[8k+7:8k]`
- `i_data_v`  in  1  `i_data` valid; one vector per cycle max; no backpressure
- `i_en_relu`  in  1  apply ReLU to this vector
- `i_rf_idx`  in  5  destination entry
- `i_rf_mux`  in  2  merge mode: 00 full, 01 low 32b, 10 high 32b, 11 saturating accumulate
- `i_clr`  in  1  single-cycle pulse; start zero sweep of the RF
- `i_rd_en`  in  1  read request
- `i_rd_idx`  in  5  read entry
- `o_rd_data`  out  64  read data, registered
- `o_rd_v`  out  1  read data valid
- `o_wr_v`  out  1  pulse: RF entry updated this cycle
- `o_wr_idx`  out  5  entry updated (valid with `o_wr_v`)
- `o_clr_busy`  out  1  clear sweep in progress
- `o_drop_err`  out  1  sticky: a write was dropped during clear

## Operation
- **S1 (input register):** on `i_data_v`, capture data, ReLU flag, idx and mux.
  - ReLU is applied at capture: a lane with MSB=1 becomes 0 when `en_relu`=1; otherwise the lane passes unchanged.
- **S2 (merge/write):** while S1 is valid, read `RF[idx]` combinationally, merge, and write at the clock edge.
  - Mode 00: new = S1 data.
  - Mode 01: `[31:0]` from S1, `[63:32]` kept.
  - Mode 10: `[63:32]` from S1, `[31:0]` kept.
  - Mode 11: per lane, 9-bit signed sum of old + S1, saturated to [-128, 127].
- **FSM states:** IDLE and CLEAR.
  - IDLE→CLEAR on `i_clr`; the counter `clr_cnt` is set to 0.
  - In CLEAR, `RF[clr_cnt]` ← 0 each cycle and `clr_cnt` increments.
  - CLEAR→IDLE after writing entry `RF_DEPTH-1`, i.e. 32 cycles. The counter wraps to 0.
  - `i_clr` while already in CLEAR is ignored.
- **Writes during CLEAR:** a write whose S2 cycle falls in CLEAR is dropped, `o_drop_err` is set, and `o_wr_v` stays 0.
  - `o_drop_err` is cleared only by an accepted `i_clr` (IDLE→CLEAR).
- **Read port:**
  - `o_rd_data` ← `RF[i_rd_idx]` one cycle after `i_rd_en`.
  - **Write-through bypass:** if an S2 write or a clear targets `i_rd_idx` in the same cycle, the newly written value is returned.
  - `o_rd_v` = registered `i_rd_en`.
- **Width rules:** all arithmetic is lane-local. There are no carries across lane boundaries.

## Timing
- **Reset values:** RF all 0, S1 valid 0, FSM IDLE, `clr_cnt` 0, and all outputs 0.
- **Write latency:** `i_data_v` at edge t → S1 valid after t → RF updated and `o_wr_v`/`o_wr_idx` asserted at edge t+1.
  - A read issued in the cycle after that edge sees the new data.
- **Back-to-back writes to the same idx:** always correct. S2 reads RF after the prior write has committed, so no forwarding is needed.
- **Read latency:** 1 cycle; full throughput (one read per cycle).
- **Clear:** `i_clr` at edge t → `o_clr_busy`=1 from t through the last sweep cycle (32 cycles), then 0.
- **Reset mid-sweep:** the RF is zeroed by reset itself; the FSM returns to IDLE.
- **Reset mid-write:** any in-flight S1 vector is discarded.

## Structure
- Shared package `vpe_pkg`:
  - `VPE_LANES`, `VPE_DW`, `VPE_RF_DEPTH`
  - mux encodings `RF_MUX_FULL` / `RF_MUX_LO` / `RF_MUX_HI` / `RF_MUX_ACC`
  - FSM state enum `wb_state_t`
- One sub-module: `vpe_lane_sat_add8`, a combinational 8-bit signed saturating adder, instantiated once per lane (8×).
- The RF is a flop array: a 2-D register, not SRAM, so the asynchronous read in S2 is legal.

## Test plan
- **Full write with ReLU:** `i_data`=0x80_7F_FF_01_00_81_10_F0, relu=1, mux=00, idx=3 → after 2 edges `RF[3]`=0x00_7F_00_01_00_00_10_00, `o_wr_idx`=3. A read of 3 returns the same value.
- **Half writes:** mux=01 with 0x...AAAAAAAA, then mux=10 with 0xBBBBBBBB... to idx 7 (relu=0) → `RF[7]`=0xBBBBBBBB_AAAAAAAA.
- **Saturating accumulate:** lanes 0x70 + 0x20 → 0x7F, 0x90 + 0xF0 → 0x80, 0x05 + 0xFE → 0x03. Back-to-back accumulates to the same idx in consecutive cycles chain correctly.
- **Bypass:** a read of idx 9 in the same cycle as the S2 write of 0x1122334455667788 to idx 9 → `o_rd_data`=0x1122334455667788 next cycle.
- **Clear with drop:** pulse `i_clr` and inject a write 5 cycles later → `o_clr_busy` high for 32 cycles, all RF entries 0, `o_drop_err`=1, no `o_wr_v`. A second `i_clr` clears `o_drop_err`.
- **Async reset mid-sweep (cycle 10):** all outputs 0 immediately, FSM IDLE, every subsequent read returns 0.
